mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single unified memory port between the instruction-fetch read channel and the load/store unit's read and write channels. It sits between the core and the memory/bus fabric. A registered grant state machine owns the port for one transaction at a time. Arbitration alternates between fetch and data when both are waiting, and a watchdog terminates transactions that never receive an acknowledge.

## Interface
- XLEN, 32, data and address width
- TIMEOUT, 255, maximum grant cycles without ack before forced termination (≥2)
---
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_re, i_addr, i_sel  in  1/XLEN/4  fetch read request (c2c_r fields)
- i_data, i_ack  out  XLEN/1  fetch read data, acknowledge
- dr_re, dr_addr, dr_sel  in  1/XLEN/4  LSU read request
- dr_data, dr_ack  out  XLEN/1  LSU read data, acknowledge
- dw_we, dw_addr, dw_sel, dw_data  in  1/XLEN/4/XLEN  LSU write request (c2c_w fields)
- dw_ack  out  1  LSU write acknowledge
- mem_re, mem_we  out  1/1  downstream strobes
- mem_addr, mem_sel, mem_wdata  out  XLEN/4/XLEN  downstream request fields
- mem_rdata, mem_ack  in  XLEN/1  downstream read data, acknowledge
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, G_I, G_DR, G_DW. Reset → IDLE, last_data=0, timer=0, bus_err=0.
- IDLE arbitration (registered, takes effect next cycle):
  - Data candidate: dw_we if asserted, else dr_re. Write beats read if both are asserted.
  - Data only → G_DW/G_DR. Fetch only → G_I.
  - Both data and fetch pending: last_data=1 → G_I; last_data=0 → data grant.
  - No request → stay in IDLE.
- In G_x: mem_addr/sel/wdata are muxed from the granted requester.
  - mem_re = granted re (G_I, G_DR); mem_we = dw_we (G_DW).
  - Non-granted strobes are 0.
- mem_ack is routed combinationally to the granted requester's ack only. All other acks are 0.
- i_data and dr_data = mem_rdata at all times. They are valid only with the matching ack.
- Exit from G_x to IDLE on any of:
  - (a) mem_ack=1;
  - (b) the granted requester drops its strobe (flush/abort); the strobe also drops downstream in the same cycle;
  - (c) timer reaches TIMEOUT-1 with no ack.
- Timeout (c): forces one-cycle ack to the requester (data = mem_rdata, undefined), sets bus_err=1, deasserts mem strobes that cycle.
- On exit: last_data = 1 if the grant was G_DR/G_DW, 0 if G_I. Abort (b) does not update last_data.
- Timer: clears on grant entry, increments each G_x cycle, saturates. It does not count in IDLE.
- bus_err: cleared only by rst_n.
- IDLE outputs: mem_re=mem_we=0, all acks 0. mem_addr/sel/wdata = 0.

## Timing
- Request seen in IDLE at cycle N → grant state and mem strobe from cycle N+1.
- Ack at cycle M (≥N+1) → requester ack in M, same cycle. Arbiter is in IDLE at M+1; next grant at M+2.
- Minimum 2 cycles per transaction; one IDLE bubble between back-to-back transactions.
- Requesters hold strobe and fields stable until ack. The arbiter does not register request fields.
- Asynchronous reset mid-grant: all outputs 0 immediately, state IDLE; the in-flight transaction is abandoned.
- mem_ack while in IDLE: ignored, no ack forwarded.

## Test plan
- Single fetch: i_re=1, i_addr=0x100 at cycle 0; memory acks at cycle 3 with 0xDEADBEEF → mem_re=1 with mem_addr=0x100 on cycles 1–3; i_ack=1 and i_data=0xDEADBEEF at cycle 3; IDLE at cycle 4.
- Contention fairness: i_re and dr_re held continuously, immediate acks. After reset, grants are G_DR, G_I, G_DR, G_I… (alternating); dr_ack and i_ack never both 1 in one cycle.
- Read/write collision: dr_re=dw_we=1 with dw_addr=0x20, dw_data=0x55, dw_sel=0b0011 → G_DW; mem_we=1, mem_wdata=0x55, mem_sel=0b0011; dr_ack=0.
- Abort: G_DR granted; dr_re drops at cycle 2 before ack → mem_re=0 at cycle 2, IDLE at cycle 3, bus_err=0. The next contention still grants data first (last_data unchanged).
- Timeout with TIMEOUT=4: dw_we held, mem_ack never asserted → mem_we on cycles 1–3, then dw_ack=1 at cycle 4 with mem_we=0. bus_err=1 from cycle 5 and stays 1 until rst_n.
- Reset mid-transaction: rst_n=0 during G_I → mem_re=0, i_ack=0 asynchronously. After release with i_re still 1, a new grant begins one cycle later.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch reads, LSU reads and LSU writes, with a per-grant timeout watchdog
// Ports: clk, rst_n (async active-low); fetch read i_re/i_addr/i_sel -> i_data/i_ack;
// LSU read dr_re/dr_addr/dr_sel -> dr_data/dr_ack; LSU write dw_we/dw_addr/dw_sel/dw_data -> dw_ack;
// downstream mem_re/mem_we/mem_addr/mem_sel/mem_wdata <- mem_rdata/mem_ack; sticky timeout flag bus_err.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_re,
  input  logic [XLEN-1:0] i_addr,
  input  logic [3:0]      i_sel,
  output logic [XLEN-1:0] i_data,
  output logic            i_ack,
  input  logic            dr_re,
  input  logic [XLEN-1:0] dr_addr,
  input  logic [3:0]      dr_sel,
  output logic [XLEN-1:0] dr_data,
  output logic            dr_ack,
  input  logic            dw_we,
  input  logic [XLEN-1:0] dw_addr,
  input  logic [3:0]      dw_sel,
  input  logic [XLEN-1:0] dw_data,
  output logic            dw_ack,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_sel,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            bus_err
);
  typedef enum logic [1:0] {IDLE, G_I, G_DR, G_DW} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            bus_err_q, bus_err_d;
  logic            busy, req, to, ack;
  assign busy = state_q != IDLE;
  assign req  = state_q == G_I ? i_re : state_q == G_DR ? dr_re : state_q == G_DW ? dw_we : 1'b0;
  // a dropped strobe is an abort, not a timeout; a timeout fakes a one-cycle ack
  assign to   = busy && req && !mem_ack && timer_q == TW'(TIMEOUT - 1);
  assign ack  = busy && (mem_ack || to);
  assign mem_re    = req && !to && (state_q == G_I || state_q == G_DR);
  assign mem_we    = req && !to && state_q == G_DW;
  assign mem_addr  = state_q == G_I ? i_addr : state_q == G_DR ? dr_addr : state_q == G_DW ? dw_addr : '0;
  assign mem_sel   = state_q == G_I ? i_sel : state_q == G_DR ? dr_sel : state_q == G_DW ? dw_sel : '0;
  assign mem_wdata = state_q == G_DW ? dw_data : '0;
  assign i_ack   = ack && state_q == G_I;
  assign dr_ack  = ack && state_q == G_DR;
  assign dw_ack  = ack && state_q == G_DW;
  assign i_data  = mem_rdata;
  assign dr_data = mem_rdata;
  assign bus_err = bus_err_q;
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timer_d   = timer_q;
    bus_err_d = bus_err_q | to;
    if (!busy) begin
      timer_d = '0;
      // data wins unless fetch is also waiting and data had the previous grant
      state_d = (dw_we || dr_re) && !(i_re && last_q) ? (dw_we ? G_DW : G_DR) : i_re ? G_I : IDLE;
    end else begin
      timer_d = &timer_q ? timer_q : timer_q + 1'b1;
      state_d = ack || !req ? IDLE : state_q;
      last_d  = ack ? state_q != G_I : last_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      bus_err_q <= bus_err_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with an ack scoreboard for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_re, dr_re, dw_we, mem_ack;
  logic [31:0] i_addr, dr_addr, dw_addr, dw_data, mem_rdata;
  logic [3:0]  i_sel, dr_sel, dw_sel;
  logic [31:0] i_data, dr_data, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        i_ack, dr_ack, dw_ack, mem_re, mem_we, bus_err;
  typedef struct {logic [1:0] who; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_pass = 0;
  int n_total = 0;
  mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_re(i_re), .i_addr(i_addr), .i_sel(i_sel), .i_data(i_data), .i_ack(i_ack),
    .dr_re(dr_re), .dr_addr(dr_addr), .dr_sel(dr_sel), .dr_data(dr_data), .dr_ack(dr_ack),
    .dw_we(dw_we), .dw_addr(dw_addr), .dw_sel(dw_sel), .dw_data(dw_data), .dw_ack(dw_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] w, input logic [31:0] d);
    exp_t e;
    e.who = w;
    e.data = d;
    exp_q.push_back(e);
  endtask
  // who encoding: 1 = fetch, 2 = LSU read, 3 = LSU write
  always @(negedge clk) begin
    if (i_ack || dr_ack || dw_ack) begin
      chk("ack_onehot", 32'($countones({i_ack, dr_ack, dw_ack})), 1);
      if (exp_q.size() == 0) chk("ack_unexpected", {30'd0, dr_ack | dw_ack, i_ack | dw_ack}, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ack_who", {30'd0, dr_ack | dw_ack, i_ack | dw_ack}, {30'd0, mon_e.who});
        if (mon_e.who != 2'd3) chk("ack_data", i_ack ? i_data : dr_data, mon_e.data);
      end
    end
  end
  initial begin
    rst_n = 0; i_re = 0; dr_re = 0; dw_we = 0; mem_ack = 0;
    i_addr = 0; dr_addr = 0; dw_addr = 0; dw_data = 0; mem_rdata = 0;
    i_sel = 0; dr_sel = 0; dw_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", bus_err, 0);
    rst_n = 1;
    // single fetch, ack on cycle 3
    cyc();
    i_re = 1; i_addr = 32'h100; i_sel = 4'hF;
    @(negedge clk);
    chk("f_idle", mem_re, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 3) begin
        mem_ack = 1; mem_rdata = 32'hDEADBEEF; push(1, 32'hDEADBEEF);
      end
      @(negedge clk);
      chk("f_re", mem_re, 1);
      chk("f_addr", mem_addr, 32'h100);
      chk("f_ack", i_ack, c == 3);
    end
    cyc();
    mem_ack = 0; i_re = 0;
    @(negedge clk);
    chk("f_done", mem_re, 0);
    // read/write collision: write wins
    cyc();
    dr_re = 1; dr_addr = 32'h24; dw_we = 1; dw_addr = 32'h20; dw_data = 32'h55; dw_sel = 4'b0011;
    cyc();
    mem_ack = 1; push(3, 0);
    @(negedge clk);
    chk("c_we", mem_we, 1);
    chk("c_re", mem_re, 0);
    chk("c_wdata", mem_wdata, 32'h55);
    chk("c_sel", {28'd0, mem_sel}, 32'h3);
    chk("c_addr", mem_addr, 32'h20);
    chk("c_drack", dr_ack, 0);
    cyc();
    mem_ack = 0; dw_we = 0; dr_re = 0;
    @(negedge clk);
    chk("c_done", mem_we, 0);
    // contention with immediate acks after a fresh reset: DR, I, DR, I...
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
    i_re = 1; dr_re = 1; i_addr = 32'h80; dr_addr = 32'h40; mem_ack = 1;
    for (int k = 0; k < 6; k++) push(k % 2 == 0 ? 2'd2 : 2'd1, 32'hC0DE0000 + 32'(1 + 2 * k));
    for (int c = 0; c < 12; c++) begin
      mem_rdata = 32'hC0DE0000 + 32'(c);
      @(negedge clk);
      if (c % 2 == 1) chk("cont_addr", mem_addr, ((c - 1) / 2) % 2 == 0 ? 32'h40 : 32'h80);
      else chk("cont_bubble", mem_re, 0);
      cyc();
    end
    i_re = 0; dr_re = 0; mem_ack = 0;
    @(negedge clk);
    chk("cont_done", mem_re, 0);
    // abort: dr_re drops before ack; fairness state unchanged
    cyc();
    dr_re = 1; dr_addr = 32'h44;
    cyc();
    @(negedge clk);
    chk("ab_grant", mem_re, 1);
    cyc();
    dr_re = 0;
    @(negedge clk);
    chk("ab_drop", mem_re, 0);
    chk("ab_noack", dr_ack, 0);
    cyc();
    i_re = 1; dr_re = 1; i_addr = 32'h80;
    @(negedge clk);
    chk("ab_idle", mem_re, 0);
    chk("ab_err", bus_err, 0);
    cyc();
    mem_ack = 1; mem_rdata = 32'h0BADF00D; push(2, 32'h0BADF00D);
    @(negedge clk);
    chk("ab_fair", mem_addr, 32'h44);
    cyc();
    mem_ack = 0; i_re = 0; dr_re = 0;
    // timeout: no ack, forced dw_ack on cycle 4
    cyc();
    dw_we = 1; dw_addr = 32'h30; dw_data = 32'h99; dw_sel = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      @(negedge clk);
      chk("to_we", mem_we, 1);
      chk("to_noack", dw_ack, 0);
    end
    cyc();
    push(3, 0);
    @(negedge clk);
    chk("to_ack", dw_ack, 1);
    chk("to_weoff", mem_we, 0);
    chk("to_errlate", bus_err, 0);
    cyc();
    dw_we = 0;
    @(negedge clk);
    chk("to_err", bus_err, 1);
    chk("to_idle", mem_we, 0);
    cyc();
    i_re = 1; i_addr = 32'h104;
    cyc();
    mem_ack = 1; mem_rdata = 32'h600DCAFE; push(1, 32'h600DCAFE);
    @(negedge clk);
    chk("to_sticky", bus_err, 1);
    cyc();
    mem_ack = 0; i_re = 0;
    // asynchronous reset in the middle of a fetch grant
    cyc();
    i_re = 1; i_addr = 32'h108;
    cyc();
    @(negedge clk);
    chk("rm_grant", mem_re, 1);
    cyc();
    mem_ack = 1;
    #1;
    chk("rm_pre", i_ack, 1);
    rst_n = 0;
    #1;
    chk("rm_re", mem_re, 0);
    chk("rm_ack", i_ack, 0);
    chk("rm_err", bus_err, 0);
    mem_ack = 0;
    cyc();
    rst_n = 1;
    @(negedge clk);
    chk("rm_idle", mem_re, 0);
    cyc();
    mem_ack = 1; mem_rdata = 32'h12345678; push(1, 32'h12345678);
    @(negedge clk);
    chk("rm_regrant", mem_re, 1);
    chk("rm_addr", mem_addr, 32'h108);
    cyc();
    mem_ack = 0; i_re = 0;
    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
